// File: rtl/pkt_write_ctrl.sv
// Packet-to-block write controller: packs a beat stream into linked memory blocks
// (payload followed by a next-pointer footer) and emits one descriptor per packet.
module pkt_write_ctrl #(
    parameter int unsigned BEAT_BYTES   = 2,
    parameter int unsigned BLOCK_BYTES  = 64,
    parameter int unsigned FOOTER_BYTES = 2,
    parameter int unsigned ADDR_W       = 10,
    parameter int unsigned LEN_W        = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [8*BEAT_BYTES-1:0]          s_data_i,
    input  logic                             s_valid_i,
    input  logic                             s_sop_i,
    input  logic                             s_eop_i,
    input  logic                             s_abort_i,
    input  logic [$clog2(BEAT_BYTES+1)-1:0]  s_bytes_i,
    output logic                             s_ready_o,
    output logic                             alloc_req_o,
    input  logic                             alloc_gnt_i,
    input  logic [ADDR_W-1:0]                alloc_idx_i,
    input  logic                             mem_ready_i,
    output logic                             mem_we_o,
    output logic [ADDR_W-1:0]                mem_addr_o,
    output logic [8*BLOCK_BYTES-1:0]         mem_wdata_o,
    output logic                             desc_valid_o,
    input  logic                             desc_ready_i,
    output logic [ADDR_W-1:0]                desc_start_o,
    output logic [LEN_W-1:0]                 desc_len_o,
    output logic [LEN_W-1:0]                 desc_blocks_o,
    output logic                             desc_err_o
);

    localparam int unsigned DATA_W        = 8 * BEAT_BYTES;
    localparam int unsigned PAYLOAD_BYTES = BLOCK_BYTES - FOOTER_BYTES;
    localparam int unsigned PAYLOAD_BEATS = PAYLOAD_BYTES / BEAT_BYTES;
    localparam int unsigned PAYLOAD_BITS  = 8 * PAYLOAD_BYTES;
    localparam int unsigned FOOTER_BITS   = 8 * FOOTER_BYTES;
    localparam int unsigned CNT_W         = $clog2(PAYLOAD_BEATS + 1);

    typedef enum logic [2:0] {IDLE, ARMED, FILL, NEXT, WRITE, DESC} state_t;

    state_t                  state, state_nx;
    logic [ADDR_W-1:0]       curr_idx, next_idx, start_idx;
    logic [PAYLOAD_BITS-1:0] payload;
    logic [FOOTER_BITS-1:0]  footer;
    logic [CNT_W-1:0]        beat_cnt;
    logic [LEN_W-1:0]        len, blocks;
    logic                    err, eop_f;
    logic                    beat_acc;
    int unsigned             beat_nbytes;
    int unsigned             slot_msb;
    logic [DATA_W-1:0]       beat_data;
    logic [LEN_W:0]          len_sum;

    assign s_ready_o     = (state == ARMED) || (state == FILL);
    assign alloc_req_o   = (state == IDLE) || (state == NEXT);
    assign mem_we_o      = (state == WRITE);
    assign desc_valid_o  = (state == DESC);
    assign mem_addr_o    = curr_idx;
    assign mem_wdata_o   = {payload, footer};
    assign desc_start_o  = start_idx;
    assign desc_len_o    = len;
    assign desc_blocks_o = blocks;
    assign desc_err_o    = err;
    assign beat_acc      = s_valid_i && s_ready_o;

    // Lanes past the valid byte count on an eop beat are zeroed so unwritten payload stays 0.
    always_comb begin
        beat_nbytes = BEAT_BYTES;
        if (s_eop_i && (s_bytes_i != '0) && (32'(s_bytes_i) < BEAT_BYTES))
            beat_nbytes = 32'(s_bytes_i);
        beat_data = s_data_i;
        for (int unsigned i = 0; i < BEAT_BYTES; i++)
            if (i >= beat_nbytes) beat_data[DATA_W-1-8*i -: 8] = '0;
        len_sum  = {1'b0, len} + (LEN_W+1)'(beat_nbytes);
        slot_msb = PAYLOAD_BITS - 1 - 32'(beat_cnt) * DATA_W;
    end

    always_comb begin
        footer = '0;
        footer[FOOTER_BITS-1 -: ADDR_W] = eop_f ? '0 : next_idx;
        footer[FOOTER_BITS-1-ADDR_W]    = eop_f;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (alloc_gnt_i) state_nx = ARMED;
            ARMED: if (beat_acc && s_sop_i) state_nx = s_eop_i ? WRITE : FILL;
            FILL: begin
                if (beat_acc) begin
                    if (s_abort_i || s_eop_i)                        state_nx = WRITE;
                    else if (beat_cnt == CNT_W'(PAYLOAD_BEATS - 1))  state_nx = NEXT;
                end
            end
            NEXT:  if (alloc_gnt_i) state_nx = WRITE;
            WRITE: if (mem_ready_i) state_nx = eop_f ? DESC : FILL;
            DESC:  if (desc_ready_i) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            curr_idx  <= '0;
            next_idx  <= '0;
            start_idx <= '0;
            payload   <= '0;
            beat_cnt  <= '0;
            len       <= '0;
            blocks    <= '0;
            err       <= 1'b0;
            eop_f     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (alloc_gnt_i) begin
                        curr_idx  <= alloc_idx_i;
                        start_idx <= alloc_idx_i;
                    end
                end
                ARMED: begin
                    if (beat_acc && s_sop_i) begin
                        payload  <= {beat_data, {(PAYLOAD_BITS-DATA_W){1'b0}}};
                        beat_cnt <= CNT_W'(1);
                        len      <= LEN_W'(beat_nbytes);
                        blocks   <= '0;
                        err      <= 1'b0;
                        eop_f    <= s_eop_i;
                    end
                end
                FILL: begin
                    if (beat_acc) begin
                        if (s_abort_i) begin
                            eop_f <= 1'b1;
                            err   <= 1'b1;
                        end else begin
                            payload[slot_msb -: DATA_W] <= beat_data;
                            beat_cnt <= beat_cnt + 1'b1;
                            eop_f    <= s_eop_i;
                            if (len_sum[LEN_W]) begin
                                len <= '1;
                                err <= 1'b1;
                            end else begin
                                len <= len_sum[LEN_W-1:0];
                            end
                        end
                    end
                end
                NEXT: if (alloc_gnt_i) next_idx <= alloc_idx_i;
                WRITE: begin
                    if (mem_ready_i) begin
                        blocks <= blocks + 1'b1;
                        if (!eop_f) begin
                            curr_idx <= next_idx;
                            payload  <= '0;
                            beat_cnt <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pkt_write_ctrl.sv
// Directed bench for pkt_write_ctrl: free-list, memory and arbiter responders plus
// hand-built expected blocks and descriptors.
module tb_pkt_write_ctrl;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned LEN_W  = 16;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [15:0]        s_data_i = '0;
    logic               s_valid_i = 1'b0, s_sop_i = 1'b0, s_eop_i = 1'b0, s_abort_i = 1'b0;
    logic [1:0]         s_bytes_i = '0;
    logic               s_ready_o;
    logic               alloc_req_o;
    logic               alloc_gnt_i = 1'b0;
    logic [ADDR_W-1:0]  alloc_idx_i = '0;
    logic               mem_ready_i = 1'b0;
    logic               mem_we_o;
    logic [ADDR_W-1:0]  mem_addr_o;
    logic [511:0]       mem_wdata_o;
    logic               desc_valid_o;
    logic               desc_ready_i = 1'b0;
    logic [ADDR_W-1:0]  desc_start_o;
    logic [LEN_W-1:0]   desc_len_o, desc_blocks_o;
    logic               desc_err_o;

    pkt_write_ctrl #(
        .BEAT_BYTES(2), .BLOCK_BYTES(64), .FOOTER_BYTES(2), .ADDR_W(ADDR_W), .LEN_W(LEN_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_sop_i(s_sop_i), .s_eop_i(s_eop_i),
        .s_abort_i(s_abort_i), .s_bytes_i(s_bytes_i), .s_ready_o(s_ready_o),
        .alloc_req_o(alloc_req_o), .alloc_gnt_i(alloc_gnt_i), .alloc_idx_i(alloc_idx_i),
        .mem_ready_i(mem_ready_i), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o),
        .desc_valid_o(desc_valid_o), .desc_ready_i(desc_ready_i), .desc_start_o(desc_start_o),
        .desc_len_o(desc_len_o), .desc_blocks_o(desc_blocks_o), .desc_err_o(desc_err_o)
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0, n_miss = 0;
    logic [ADDR_W-1:0] gnt_tab [16];
    int unsigned gnt_wr = 0, gnt_rd = 0;
    int unsigned gnt_delay = 0, mem_delay = 0, desc_delay = 0;
    int unsigned gnt_wait = 0, we_wait = 0, dv_wait = 0;
    int unsigned req_cyc = 0, we_cyc = 0, dv_cyc = 0, unstable = 0, overlap = 0;
    logic we_hold = 1'b0, dv_hold = 1'b0;
    logic [ADDR_W-1:0] hold_addr = '0;
    logic [511:0] hold_data = '0;
    logic [42:0] hold_desc = '0;
    logic [ADDR_W-1:0] wr_addr [$];
    logic [511:0]      wr_data [$];
    logic [ADDR_W-1:0] d_start [$];
    logic [LEN_W-1:0]  d_len [$];
    logic [LEN_W-1:0]  d_blk [$];
    logic              d_err [$];
    int unsigned wr_seen = 0, d_seen = 0;
    logic [7:0] pkt [128];

    // Responders change their outputs just after the active edge.
    always @(posedge clk) begin
        #1;
        alloc_gnt_i  = alloc_req_o && (gnt_rd < gnt_wr) && (gnt_wait >= gnt_delay);
        alloc_idx_i  = gnt_tab[gnt_rd % 16];
        mem_ready_i  = mem_we_o && (we_wait >= mem_delay);
        desc_ready_i = desc_valid_o && (dv_wait >= desc_delay);
    end

    // Monitor on the falling edge: handshakes seen here complete on the next rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (alloc_req_o) req_cyc++;
            if (alloc_req_o && alloc_gnt_i) begin
                gnt_rd++;
                gnt_wait = 0;
            end else if (alloc_req_o) begin
                gnt_wait++;
            end
            if (mem_we_o) begin
                we_cyc++;
                if (we_hold && (mem_addr_o !== hold_addr || mem_wdata_o !== hold_data)) unstable++;
                hold_addr = mem_addr_o;
                hold_data = mem_wdata_o;
            end
            we_hold = mem_we_o && !mem_ready_i;
            if (mem_we_o && mem_ready_i) begin
                wr_addr.push_back(mem_addr_o);
                wr_data.push_back(mem_wdata_o);
                we_wait = 0;
            end else if (mem_we_o) begin
                we_wait++;
            end
            if (desc_valid_o) begin
                dv_cyc++;
                if (dv_hold && ({desc_start_o, desc_len_o, desc_blocks_o, desc_err_o} !== hold_desc))
                    unstable++;
                hold_desc = {desc_start_o, desc_len_o, desc_blocks_o, desc_err_o};
            end
            dv_hold = desc_valid_o && !desc_ready_i;
            if (desc_valid_o && desc_ready_i) begin
                d_start.push_back(desc_start_o);
                d_len.push_back(desc_len_o);
                d_blk.push_back(desc_blocks_o);
                d_err.push_back(desc_err_o);
                dv_wait = 0;
            end else if (desc_valid_o) begin
                dv_wait++;
            end
            if (s_ready_o && (mem_we_o || desc_valid_o || alloc_req_o)) overlap++;
        end
    end

    task automatic chk(input string tag, input logic [511:0] act, input logic [511:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [511:0] exp_blk(input int unsigned first, input int unsigned cnt,
                                             input logic [ADDR_W-1:0] nxt, input logic eop);
        logic [511:0] r;
        r = '0;
        for (int unsigned j = 0; j < cnt; j++) r[511-8*j -: 8] = pkt[first+j];
        if (!eop) r[15:6] = nxt;
        r[5] = eop;
        return r;
    endfunction

    task automatic fill_pkt(input int unsigned seed);
        for (int unsigned k = 0; k < 128; k++) pkt[k] = 8'(seed * 31 + k * 13 + 7);
    endtask

    task automatic push_gnt(input logic [ADDR_W-1:0] idx);
        gnt_tab[gnt_wr % 16] = idx;
        gnt_wr++;
    endtask

    task automatic send_beat(input logic [15:0] d, input logic sop, input logic eop,
                             input logic abort, input logic [1:0] nb, output int unsigned stall);
        bit acc;
        acc   = 1'b0;
        stall = 0;
        s_data_i = d; s_sop_i = sop; s_eop_i = eop; s_abort_i = abort; s_bytes_i = nb;
        s_valid_i = 1'b1;
        for (int i = 0; i < 300 && !acc; i++) begin
            @(negedge clk);
            if (s_ready_o) acc = 1'b1;
            else           stall++;
            @(posedge clk);
            #1;
        end
        s_valid_i = 1'b0; s_sop_i = 1'b0; s_eop_i = 1'b0; s_abort_i = 1'b0;
        if (!acc) chk("beat_accept", acc, 1);
    endtask

    task automatic send_pkt(input int unsigned nbytes, input int unsigned abort_at,
                            input int unsigned mark_beat, output int unsigned mark_stall,
                            output int unsigned req_first);
        int unsigned nbeats, st;
        nbeats = (nbytes + 1) / 2;
        mark_stall = 0;
        req_first  = 0;
        for (int unsigned b = 0; b < nbeats; b++) begin
            logic [15:0] d;
            logic        last;
            logic [1:0]  nb;
            if (b == abort_at) begin
                send_beat(16'hFFFF, 1'b0, 1'b0, 1'b1, 2'd0, st);
                break;
            end
            last = (b == nbeats - 1);
            d    = {pkt[2*b], (2*b+1 < nbytes) ? pkt[2*b+1] : 8'h00};
            nb   = last ? ((nbytes - 2*b >= 2) ? 2'd2 : 2'd1) : 2'd0;
            send_beat(d, b == 0, last, 1'b0, nb, st);
            if (b == 0) req_first = req_cyc;
            if (b == mark_beat) mark_stall = st;
        end
    endtask

    task automatic wait_desc(input string tag);
        for (int i = 0; i < 300 && d_start.size() <= d_seen; i++) begin
            @(posedge clk);
            #1;
        end
        chk({tag, "_desc_seen"}, d_start.size() > d_seen, 1);
    endtask

    task automatic check_desc(input string tag, input logic [ADDR_W-1:0] st, input logic [LEN_W-1:0] ln,
                              input logic [LEN_W-1:0] bk, input logic er);
        if (d_start.size() > d_seen) begin
            chk({tag, "_start"},  d_start[d_seen], st);
            chk({tag, "_len"},    d_len[d_seen],   ln);
            chk({tag, "_blocks"}, d_blk[d_seen],   bk);
            chk({tag, "_err"},    d_err[d_seen],   er);
            d_seen++;
        end
    endtask

    task automatic check_wr(input string tag, input logic [ADDR_W-1:0] a, input logic [511:0] d);
        if (wr_addr.size() > wr_seen) begin
            chk({tag, "_addr"}, wr_addr[wr_seen], a);
            chk({tag, "_data"}, wr_data[wr_seen], d);
            wr_seen++;
        end else begin
            chk({tag, "_present"}, wr_addr.size(), wr_seen + 1);
        end
    endtask

    initial begin
        int unsigned stall, rq, we0, dv0;

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_alloc_req", alloc_req_o, 1);
        chk("rst_s_ready", s_ready_o, 0);
        chk("rst_mem_we", mem_we_o, 0);
        chk("rst_mem_addr", mem_addr_o, 0);
        chk("rst_mem_wdata", mem_wdata_o, 0);
        chk("rst_desc_valid", desc_valid_o, 0);
        chk("rst_desc_fields", {desc_start_o, desc_len_o, desc_blocks_o, desc_err_o}, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_alloc_req", alloc_req_o, 1);

        // Exactly one full block: no second allocation.
        fill_pkt(1);
        push_gnt(10'd5);
        send_pkt(62, 999, 999, stall, rq);
        wait_desc("t1");
        chk("t1_no_next_req", req_cyc - rq, 0);
        check_wr("t1_w0", 10'd5, exp_blk(0, 62, '0, 1'b1));
        chk("t1_n_writes", wr_addr.size(), wr_seen);
        check_desc("t1", 10'd5, 16'd62, 16'd1, 1'b0);

        // One byte spills into a second block.
        fill_pkt(2);
        push_gnt(10'd5);
        push_gnt(10'd9);
        send_pkt(63, 999, 31, stall, rq);
        wait_desc("t2");
        chk("t2_next_req", req_cyc - rq, 1);
        chk("t2_stall", stall, 2);
        check_wr("t2_w0", 10'd5, exp_blk(0, 62, 10'd9, 1'b0));
        check_wr("t2_w1", 10'd9, exp_blk(62, 1, '0, 1'b1));
        chk("t2_n_writes", wr_addr.size(), wr_seen);
        check_desc("t2", 10'd5, 16'd63, 16'd2, 1'b0);

        // Single partial sop+eop beat.
        fill_pkt(3);
        pkt[0] = 8'hAB;
        push_gnt(10'd3);
        send_pkt(1, 999, 999, stall, rq);
        wait_desc("t3");
        check_wr("t3_w0", 10'd3, exp_blk(0, 1, '0, 1'b1));
        chk("t3_n_writes", wr_addr.size(), wr_seen);
        check_desc("t3", 10'd3, 16'd1, 16'd1, 1'b0);

        // Abort on beat 10.
        fill_pkt(4);
        push_gnt(10'd7);
        send_pkt(40, 10, 999, stall, rq);
        wait_desc("t4");
        check_wr("t4_w0", 10'd7, exp_blk(0, 20, '0, 1'b1));
        chk("t4_n_writes", wr_addr.size(), wr_seen);
        check_desc("t4", 10'd7, 16'd20, 16'd1, 1'b1);

        // Stray non-sop beats, then memory and arbiter backpressure.
        fill_pkt(5);
        push_gnt(10'd12);
        mem_delay  = 5;
        desc_delay = 3;
        send_beat(16'h1234, 1'b0, 1'b0, 1'b0, 2'd0, stall);
        send_beat(16'h5678, 1'b0, 1'b1, 1'b0, 2'd2, stall);
        chk("t5_no_stray_write", wr_addr.size(), wr_seen);
        we0 = we_cyc;
        dv0 = dv_cyc;
        send_pkt(4, 999, 999, stall, rq);
        wait_desc("t5");
        chk("t5_we_cycles", we_cyc - we0, 6);
        chk("t5_desc_cycles", dv_cyc - dv0, 4);
        chk("t5_stable", unstable, 0);
        check_wr("t5_w0", 10'd12, exp_blk(0, 4, '0, 1'b1));
        chk("t5_n_writes", wr_addr.size(), wr_seen);
        check_desc("t5", 10'd12, 16'd4, 16'd1, 1'b0);
        chk("t5_n_desc", d_start.size(), d_seen);
        mem_delay  = 0;
        desc_delay = 0;

        // Allocation delayed 7 cycles in NEXT.
        fill_pkt(6);
        push_gnt(10'd20);
        push_gnt(10'd21);
        gnt_delay = 7;
        send_pkt(66, 999, 31, stall, rq);
        wait_desc("t6");
        chk("t6_next_req", req_cyc - rq, 8);
        chk("t6_stall", stall, 9);
        check_wr("t6_w0", 10'd20, exp_blk(0, 62, 10'd21, 1'b0));
        check_wr("t6_w1", 10'd21, exp_blk(62, 4, '0, 1'b1));
        chk("t6_n_writes", wr_addr.size(), wr_seen);
        check_desc("t6", 10'd20, 16'd66, 16'd2, 1'b0);
        gnt_delay = 0;

        chk("ready_overlap", overlap, 0);
        chk("final_stable", unstable, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
